// File: rtl/cs_resolver.sv
// Digit-serial carry-save resolver: s = p + q over D cycles, then up to three
// committing subtractions of m leave s mod m.  Needs D = N/W >= 3.
module cs_resolver #(
    parameter int N = 512,
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] p,
    input  logic [N-1:0] q,
    input  logic [N-1:0] m,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_r,
    output logic [1:0]   dbg_state,
    output logic [1:0]   dbg_pass
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; ready/valid come only from state, never from the other side.
    localparam int D  = N / W;
    localparam int DW = (D > 1) ? $clog2(D) : 1;
    localparam logic [DW-1:0] LAST = DW'(D - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, SUB = 2'd2, DONE = 2'd3} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   dig_q, dig_d;
    logic [1:0]      pass_q, pass_d;
    logic            cb_q, cb_d;
    logic [N-1:0]    p_q, p_d, q_q, q_d, m_q, m_d;
    logic [N-1:0]    s_lo_q, s_lo_d;
    logic            s_hi_q, s_hi_d;
    logic [N-W-1:0]  t_q, t_d;
    logic [N-1:0]    out_r_q, out_r_d;

    logic [W:0]      add_sum;
    logic [W:0]      sub_diff;
    logic            fin_borrow;
    logic            t_top;

    always_comb begin
        add_sum    = {1'b0, p_q[W-1:0]} + {1'b0, q_q[W-1:0]} + {{W{1'b0}}, cb_q};
        sub_diff   = {1'b0, s_lo_q[W-1:0]} - {1'b0, m_q[W-1:0]} - {{W{1'b0}}, cb_q};
        fin_borrow = ~s_hi_q & sub_diff[W];
        t_top      = s_hi_q ^ sub_diff[W];

        state_d = state_q;
        dig_d   = dig_q;
        pass_d  = pass_q;
        cb_d    = cb_q;
        p_d     = p_q;
        q_d     = q_q;
        m_d     = m_q;
        s_lo_d  = s_lo_q;
        s_hi_d  = s_hi_q;
        t_d     = t_q;
        out_r_d = out_r_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    p_d     = p;
                    q_d     = q;
                    m_d     = m;
                    dig_d   = '0;
                    cb_d    = 1'b0;
                    pass_d  = 2'd0;
                    state_d = ADD;
                end
            end
            ADD: begin
                p_d    = p_q >> W;
                q_d    = q_q >> W;
                s_lo_d = {add_sum[W-1:0], s_lo_q[N-1:W]};
                cb_d   = add_sum[W];
                dig_d  = dig_q + 1'b1;
                if (dig_q == LAST) begin
                    s_hi_d  = add_sum[W];
                    cb_d    = 1'b0;
                    dig_d   = '0;
                    state_d = SUB;
                end
            end
            SUB: begin
                // s and m rotate one digit per cycle and are back in place after D cycles
                s_lo_d = {s_lo_q[W-1:0], s_lo_q[N-1:W]};
                m_d    = {m_q[W-1:0], m_q[N-1:W]};
                t_d    = {sub_diff[W-1:0], t_q[N-W-1:W]};
                cb_d   = sub_diff[W];
                dig_d  = dig_q + 1'b1;
                if (dig_q == LAST) begin
                    cb_d  = 1'b0;
                    dig_d = '0;
                    if (!fin_borrow && pass_q != 2'd3) begin
                        s_lo_d = {sub_diff[W-1:0], t_q};
                        s_hi_d = t_top;
                        pass_d = pass_q + 2'd1;
                    end else begin
                        out_r_d = s_lo_d;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            dig_q   <= '0;
            pass_q  <= 2'd0;
            cb_q    <= 1'b0;
            p_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            s_lo_q  <= '0;
            s_hi_q  <= 1'b0;
            t_q     <= '0;
            out_r_q <= '0;
        end else begin
            state_q <= state_d;
            dig_q   <= dig_d;
            pass_q  <= pass_d;
            cb_q    <= cb_d;
            p_q     <= p_d;
            q_q     <= q_d;
            m_q     <= m_d;
            s_lo_q  <= s_lo_d;
            s_hi_q  <= s_hi_d;
            t_q     <= t_d;
            out_r_q <= out_r_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_r     = out_r_q;
    assign dbg_state = state_q;
    assign dbg_pass  = pass_q;

endmodule
